from_dec: RTL
=============

Name: from_dec

Overview:
- Converts four ASCII decimal characters (thousands, hundreds, tens, units) into an unsigned binary value.
- It is the inverse of the team's binary-to-ASCII-decimal converter. It serves UART/keypad paths where typed numbers (e.g. ADC thresholds, DAC setpoints) must become binary.
- Conversion is sequential reverse double-dabble: shift right, then subtract 3 from every BCD nibble >= 8.

Parameters:
- MAX_VALUE, 4095: clamp ceiling used only when RANGE_CHECK_EN is defined. Legal range 0..9999.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  the four digit inputs hold a number to convert.
- in_ready  output  1  high only in IDLE; a transfer occurs on a posedge where in_valid && in_ready.
- thousands  input  8  ASCII digit, most significant.
- hundreds  input  8  ASCII digit.
- tens  input  8  ASCII digit.
- units  input  8  ASCII digit, least significant.
- value  output  14  converted binary result (0..9999).
- out_valid  output  1  one-cycle pulse when value/err/ovf are updated.
- err  output  1  last accepted input contained a non-digit character.
- ovf  output  1  last result exceeded MAX_VALUE (RANGE_CHECK_EN only).

Behaviour:
- Reset (rstn low at posedge), regardless of state:
  - state=IDLE, value=0, out_valid=0, err=0, ovf=0.
  - Internal bcd[15:0]=0, bin[13:0]=0, step=0.
  - Reset mid-conversion aborts it; no out_valid is produced for the aborted request.
- States: IDLE, CHECK, SHIFT, ADJUST, DONE.
- IDLE:
  - in_ready=1.
  - On transfer, capture all four characters into internal registers, then go to CHECK.
  - Inputs are ignored in every other state.
- CHECK (1 cycle):
  - Each char must be 0x30..0x39.
  - If any char fails: bin=0, set an internal error flag, go to DONE.
  - Otherwise: bcd = {th-0x30, hu-0x30, te-0x30, un-0x30}, bin=0, step=0, go to SHIFT.
- SHIFT:
  - {bcd,bin} <= {bcd,bin} >> 1, i.e. bcd[0] moves into bin[13] and bcd[15] gets 0.
  - Go to ADJUST.
- ADJUST:
  - For each nibble of bcd independently: if nibble >= 8, nibble -= 3. All four nibbles are updated in the same cycle; no borrow crosses nibbles.
  - If step==13, go to DONE. Otherwise step++ and go to SHIFT.
  - 14 shift/adjust pairs in total. After the final pair bcd is 0 for any valid input, and bin holds the result.
- DONE (1 cycle):
  - Register value=bin and err=error flag.
  - Apply the RANGE_CHECK_EN rule to value/ovf.
  - Pulse out_valid=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Let the accepting edge be edge 0. out_valid is high in the cycle after edge 30 for a valid input, and after edge 2 for an invalid input.
  - in_ready is low from edge 0 until the edge that leaves DONE.
  - Minimum spacing between accepted requests: 31 cycles (valid input) or 3 cycles (invalid input).
- value, err and ovf hold their last result between out_valid pulses. A failing input produces value=0, err=1, ovf=0.
- in_valid held high continuously: a new request is accepted on the first IDLE cycle after DONE, using the inputs present at that edge.

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined: in DONE, if err==0 and bin > MAX_VALUE, then value=MAX_VALUE and ovf=1. Otherwise value=bin and ovf=0.
- Undefined: no comparator is built, ovf is tied to 0, and value=bin always. MAX_VALUE is unused.

Test Plan:
- "4095" (0x34,0x30,0x39,0x35) accepted at edge 0 -> out_valid one cycle after edge 30; value=4095 (0xFFF), err=0, ovf=0.
- "9999" -> value=9999 (0x270F) without RANGE_CHECK_EN. With RANGE_CHECK_EN and MAX_VALUE=4095 -> value=4095, ovf=1.
- "12a4" -> out_valid after edge 2; err=1, value=0. A following "0000" -> value=0, err=0.
- in_valid held high with "0007" then "1000" -> in_ready low during conversion; exactly two out_valid pulses, 31 cycles apart, values 7 then 1000.
- "0500" accepted, rstn low at edge 10 for 1 cycle, then "0042" -> no pulse for 500; single out_valid with value=42; all outputs 0 immediately after reset.
- Sweep all values 0..9999 as ASCII -> value equals the integer each time. Cross-check against the binary-to-ASCII converter in a loopback for 0..4095.

Source files
------------

// File: rtl/from_dec_if.sv
// Handshake and data bundle for the ASCII-decimal to binary converter.
// The master drives the four digit characters; the slave returns the result.
interface from_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  thousands;
  logic [7:0]  hundreds;
  logic [7:0]  tens;
  logic [7:0]  units;
  logic [13:0] value;
  logic        out_valid;
  logic        err;
  logic        ovf;

  modport master (
    output in_valid, thousands, hundreds, tens, units,
    input  in_ready, value, out_valid, err, ovf
  );

  modport slave (
    input  in_valid, thousands, hundreds, tens, units,
    output in_ready, value, out_valid, err, ovf
  );
endinterface

// File: rtl/from_dec.sv
// Four ASCII decimal digits to 14-bit binary using sequential reverse double-dabble.
// Optional macro RANGE_CHECK_EN clamps results above MAX_VALUE and raises ovf.
module from_dec #(
  parameter int MAX_VALUE = 4095
) (
  input logic   clk,
  input logic   rstn,
  from_dec_if.slave bus
);

  if (MAX_VALUE < 0 || MAX_VALUE > 9999) begin : g_bad_max
    $error("from_dec: MAX_VALUE must lie in 0..9999");
  end

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ADJUST, DONE} state_t;

  state_t      state;
  logic [7:0]  th_q;
  logic [7:0]  hu_q;
  logic [7:0]  te_q;
  logic [7:0]  un_q;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic [3:0]  step;
  logic        err_flag;
  logic        digits_ok;
  logic [15:0] bcd_adj;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  always_comb begin
    digits_ok = is_digit(th_q) && is_digit(hu_q) && is_digit(te_q) && is_digit(un_q);
    bcd_adj   = {fix_nibble(bcd[15:12]), fix_nibble(bcd[11:8]),
                 fix_nibble(bcd[7:4]),   fix_nibble(bcd[3:0])};
  end

  assign bus.in_ready = (state == IDLE);

`ifndef RANGE_CHECK_EN
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      th_q          <= '0;
      hu_q          <= '0;
      te_q          <= '0;
      un_q          <= '0;
      bcd           <= '0;
      bin           <= '0;
      step          <= '0;
      err_flag      <= 1'b0;
      bus.value     <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
`ifdef RANGE_CHECK_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            th_q  <= bus.thousands;
            hu_q  <= bus.hundreds;
            te_q  <= bus.tens;
            un_q  <= bus.units;
            state <= CHECK;
          end
        end
        CHECK: begin
          bin  <= '0;
          step <= '0;
          if (!digits_ok) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            // For '0'..'9' the low nibble of the character is the digit itself.
            err_flag <= 1'b0;
            bcd      <= {th_q[3:0], hu_q[3:0], te_q[3:0], un_q[3:0]};
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {1'b0, bcd, bin[13:1]};
          state      <= ADJUST;
        end
        ADJUST: begin
          bcd <= bcd_adj;
          if (step == 4'd13) begin
            state <= DONE;
          end else begin
            step  <= step + 4'd1;
            state <= SHIFT;
          end
        end
        DONE: begin
          bus.out_valid <= 1'b1;
          bus.err       <= err_flag;
`ifdef RANGE_CHECK_EN
          if (!err_flag && (bin > 14'(MAX_VALUE))) begin
            bus.value <= 14'(MAX_VALUE);
            bus.ovf   <= 1'b1;
          end else begin
            bus.value <= bin;
            bus.ovf   <= 1'b0;
          end
`else
          bus.value <= bin;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
